ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage sitting directly upstream of the instruction cache and downstream-feeding the decoder. Owns the program counter, issues one word-aligned fetch at a time on the cache request port, and buffers fetched `{pc, insn}` pairs in a small queue toward decode. It also handles control-flow redirects and `fence.i` flushes without ever changing the cache address while a miss is outstanding.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `QDEPTH_LOG2`, default 1: log2 of queue entries (default 2 entries).

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `redirect_valid`  in  1  one-cycle request to restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new PC. Bits [1:0] are ignored and forced to 0.
- `fence_i`  in  1  one-cycle request to invalidate the instruction cache.
- `cache_valid`  out  1  fetch request.
- `cache_ready`  in  1  hit. Data is valid in the same cycle.
- `cache_addr`  out  32  fetch address, equal to the PC.
- `cache_rdata`  in  32  fetched word.
- `cache_flush`  out  1  invalidate pulse to the cache.
- `dec_valid`  out  1  queue head is valid.
- `dec_ready`  in  1  decoder accepts the head.
- `dec_pc`  out  32  PC of the head entry.
- `dec_insn`  out  32  instruction of the head entry.

## Operation
- **State:**
  - `pc`.
  - Queue of `2^QDEPTH_LOG2` entries × 64 bits, with a count.
  - `redir_pend` and `redir_pc`.
  - `fence_pend`.
- **Fetch request:** `cache_valid = !rst && count < DEPTH && !flush_cycle`.
- **In-flight miss** is defined as `cache_valid && !cache_ready`.
  - `cache_addr` must remain stable throughout.
  - `pc` may only change on a cycle where `cache_ready` is high or `cache_valid` is low.
- **Accept:** when `cache_valid && cache_ready && !redir_pend && !redirect_valid`:
  - push `{pc, cache_rdata}` into the queue;
  - `pc <= pc + 4`, wrapping modulo 2^32 (0xFFFF_FFFC → 0).
- **Redirect** (`redirect_valid` high):
  - The queue is flushed immediately, so `count` becomes 0 next cycle, including when a pop occurs in the same cycle.
  - If no miss is in flight, `pc <= {redirect_pc[31:2], 2'b00}` next cycle.
  - If a miss is in flight, latch `redir_pend`/`redir_pc`. When that miss completes (`cache_ready`), discard the returned word, load `pc` from `redir_pc`, and clear `redir_pend`.
  - A newer redirect overwrites `redir_pc`.
- **fence_i:** sets `fence_pend`.
  - Once no miss is in flight, drive one flush cycle: `cache_flush = 1`, `cache_valid = 0`. Then clear `fence_pend`.
  - `cache_flush` is never high in a cycle where `cache_valid` is high.
- **fence_i together with redirect:** flush first, then fetch from the redirect PC.
- **Queue:**
  - Pop when `dec_valid && dec_ready`.
  - Push and pop in the same cycle are allowed whenever a push is permitted.
  - The head drives `dec_pc`/`dec_insn` directly from registers.

## Timing
- **Reset values:**
  - `pc = RESET_PC`; queue empty; `redir_pend = fence_pend = 0`.
  - Outputs: `cache_valid = 0`, `cache_flush = 0`, `dec_valid = 0`.
  - `cache_addr = RESET_PC`.
  - `dec_pc` and `dec_insn` are don't-care while `dec_valid = 0`.
- **Reset mid-miss:** takes effect at the next edge; all pending state is cleared.
- **After reset deassert:** the first cycle has `cache_valid = 1`.
- **Hit latency:** a hit in cycle N gives `dec_valid` in N+1. Sustained throughput is 1 instruction/cycle with all hits and `dec_ready = 1`.
- **Redirect, no miss in flight:** redirect in N gives `cache_addr = redirect_pc` and `dec_valid = 0` in N+1.
- **Redirect mid-miss:** the old address is held until `cache_ready`. The new address appears the cycle after.
- **Queue full:** `cache_valid` is low. It rises the cycle after a pop.
- **Flush cycle:** costs exactly one fetch bubble.

## Structure
- Shared definitions file `yarv_defs`: `INSN_BYTES = 4`, default `RESET_PC`, and the PC width of 32.
- Sub-module `fetch_queue`: a synchronous FIFO with parameterised width/depth, plus `push`, `pop`, `clear`, `count`, and head outputs. `clear` has priority over `push`.
- `ifetch` holds the PC and the redirect/fence control around it.

## Test plan
- **Reset, all hits:** reset with `RESET_PC = 0x100`, cache always ready, `rdata = addr ^ 0xA5A5A5A5`, `dec_ready = 1` → `dec_pc` = 0x100, 0x104, 0x108 on consecutive cycles, and every `dec_insn` matches.
- **Backpressure:** `dec_ready = 0` for 5 cycles → queue fills to 2 entries, `cache_valid` drops, no entry is lost or duplicated; order is resumed correctly on release.
- **Redirect during miss:** 4-cycle miss at 0x200, redirect to 0x1003 in miss cycle 2 → `cache_addr` holds 0x200 until ready, the 0x200 word is never presented, the next `dec_pc` is 0x1000.
- **fence_i during miss:** `fence_i` issued while a miss is outstanding → `cache_flush` is pulsed once after the miss completes, with `cache_valid = 0` that cycle.
- **Boundary:** redirect to 0xFFFFFFFC → the next two `dec_pc` values are 0xFFFFFFFC then 0x00000000.
- **Simultaneous events:** redirect in the same cycle as a hit and a pop → the hit word is dropped, `dec_valid = 0` next cycle, and fetch resumes at the redirect target.

Source files
------------

// File: rtl/yarv_defs.sv
// Shared definitions for the YARV fetch path: PC width, instruction size,
// reset vector and the {pc, insn} entry carried toward decode.
package yarv_defs;
    localparam int XLEN       = 32;
    localparam int INSN_BYTES = 4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
    } fetch_entry_t;

    // Drop the sub-word bits so every fetch is instruction aligned.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(INSN_BYTES - 1);
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO between fetch and decode; the head is presented
// straight from the entry registers. Clear wins over push.
module fetch_queue #(
    parameter int WIDTH      = 64,
    parameter int DEPTH_LOG2 = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    input  logic                  clear,
    output logic [DEPTH_LOG2:0]   count,
    output logic [WIDTH-1:0]      head_data
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [WIDTH-1:0]      entries [DEPTH];
    logic                  full, empty, do_push, do_pop, wr_en;

    // The count only reaches 2^DEPTH_LOG2 when full, so its top bit is the full flag.
    assign full    = count_q[DEPTH_LOG2];
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign wr_en   = do_push && !clear;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_q, entry_d;

            always_comb begin
                entry_d = entry_q;
                if (wr_en && (wr_ptr_q == DEPTH_LOG2'(gi))) entry_d = push_data;
            end

            always_ff @(posedge clk) begin
                entry_q <= entry_d;
            end

            assign entries[gi] = entry_q;
        end
    endgenerate

    assign count     = count_q;
    assign head_data = entries[rd_ptr_q];
endmodule

// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, issues one aligned fetch at a time and
// defers redirects / icache flushes until any outstanding miss completes.
module ifetch
    import yarv_defs::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int              QDEPTH_LOG2 = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            fence_i,
    output logic            cache_valid,
    input  logic            cache_ready,
    output logic [XLEN-1:0] cache_addr,
    input  logic [XLEN-1:0] cache_rdata,
    output logic            cache_flush,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_insn
);
    logic [XLEN-1:0]      pc_q, pc_d;
    logic [XLEN-1:0]      redir_pc_q, redir_pc_d;
    logic                 redir_pend_q, redir_pend_d;
    logic                 fence_pend_q, fence_pend_d;
    logic                 miss_q, miss_d;

    logic [QDEPTH_LOG2:0] q_count;
    logic                 q_full, q_push, q_pop;
    logic                 flush_cycle, miss_now, hit;
    fetch_entry_t         push_entry, head_entry;

    // A miss seen last cycle is still being serviced, so the request must be held.
    assign flush_cycle = fence_pend_q && !miss_q;
    assign q_full      = q_count[QDEPTH_LOG2];
    assign cache_valid = !rst && !q_full && !flush_cycle;
    assign cache_flush = !rst && flush_cycle;
    assign cache_addr  = pc_q;

    assign miss_now = cache_valid && !cache_ready;
    assign hit      = cache_valid && cache_ready;
    assign q_push   = hit && !redir_pend_q && !redirect_valid;
    assign q_pop    = dec_valid && dec_ready;

    assign push_entry.pc   = pc_q;
    assign push_entry.insn = cache_rdata;

    always_comb begin
        pc_d         = pc_q;
        redir_pc_d   = redir_pc_q;
        redir_pend_d = redir_pend_q;
        fence_pend_d = fence_pend_q;
        miss_d       = miss_now;

        if (flush_cycle) fence_pend_d = 1'b0;
        if (fence_i)     fence_pend_d = 1'b1;

        if (redirect_valid) begin
            if (miss_now) begin
                redir_pend_d = 1'b1;
                redir_pc_d   = align_pc(redirect_pc);
            end else begin
                pc_d         = align_pc(redirect_pc);
                redir_pend_d = 1'b0;
            end
        end else if (hit) begin
            // The word returned for a redirected miss is dropped here.
            if (redir_pend_q) begin
                pc_d         = redir_pc_q;
                redir_pend_d = 1'b0;
            end else begin
                pc_d = pc_q + XLEN'(INSN_BYTES);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            redir_pc_q   <= '0;
            redir_pend_q <= 1'b0;
            fence_pend_q <= 1'b0;
            miss_q       <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            redir_pc_q   <= redir_pc_d;
            redir_pend_q <= redir_pend_d;
            fence_pend_q <= fence_pend_d;
            miss_q       <= miss_d;
        end
    end

    fetch_queue #(
        .WIDTH      ($bits(fetch_entry_t)),
        .DEPTH_LOG2 (QDEPTH_LOG2)
    ) u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data (push_entry),
        .pop       (q_pop),
        .clear     (redirect_valid),
        .count     (q_count),
        .head_data (head_entry)
    );

    assign dec_valid = (q_count != '0);
    assign dec_pc    = head_entry.pc;
    assign dec_insn  = head_entry.insn;
endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a queue-level reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_ifetch;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] KEY    = 32'hA5A5_A5A5;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fence_i;
    logic        cache_valid;
    logic        cache_ready;
    logic [31:0] cache_addr;
    logic [31:0] cache_rdata;
    logic        cache_flush;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_insn;

    ifetch #(
        .RESET_PC    (RST_PC),
        .QDEPTH_LOG2 (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fence_i        (fence_i),
        .cache_valid    (cache_valid),
        .cache_ready    (cache_ready),
        .cache_addr     (cache_addr),
        .cache_rdata    (cache_rdata),
        .cache_flush    (cache_flush),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_insn       (dec_insn)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Cache: every address hits except miss_addr, which misses until cycle miss_end.
    logic [31:0] miss_addr;
    int          miss_end;
    assign cache_rdata = cache_addr ^ KEY;
    assign cache_ready = !((cache_addr == miss_addr) && (cyc < miss_end));

    int checks = 0;
    int errors = 0;
    int flush_cnt = 0;

    logic [63:0] m_q[$];
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_rpc = 32'h0;
    logic        m_rp = 1'b0;
    logic        m_fence = 1'b0;
    logic        m_miss = 1'b0;
    logic        m_ok = 1'b0;

    logic [31:0] got_pc[$];
    logic [31:0] got_insn[$];
    int          got_cyc[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Compare DUT against the reference, log decoder transfers, then advance the reference.
    task automatic model_cycle();
        logic        e_cv, e_fl, e_dv, miss_now, hit, pop;
        logic [31:0] tgt;
        logic [63:0] head;
        e_fl = !rst && m_fence && !m_miss;
        e_cv = !rst && (m_q.size() < DEPTH) && !e_fl;
        e_dv = (m_q.size() != 0);
        chk1("cache_valid", cache_valid, e_cv);
        chk1("cache_flush", cache_flush, e_fl);
        if (m_ok) begin
            chk32("cache_addr", cache_addr, m_pc);
            chk1("dec_valid", dec_valid, e_dv);
            if (e_dv) begin
                head = m_q[0];
                chk32("dec_pc", dec_pc, head[63:32]);
                chk32("dec_insn", dec_insn, head[31:0]);
            end
        end
        if (cache_flush === 1'b1) flush_cnt++;
        if (!rst && dec_valid === 1'b1 && dec_ready) begin
            got_pc.push_back(dec_pc);
            got_insn.push_back(dec_insn);
            got_cyc.push_back(cyc);
            $display("xfer cyc=%0d pc=%h insn=%h", cyc, dec_pc, dec_insn);
        end

        if (rst) begin
            m_q.delete();
            m_pc    = RST_PC;
            m_rp    = 1'b0;
            m_fence = 1'b0;
            m_miss  = 1'b0;
            m_ok    = 1'b1;
        end else begin
            miss_now = e_cv && !cache_ready;
            hit      = e_cv && cache_ready;
            pop      = e_dv && dec_ready;
            tgt      = {redirect_pc[31:2], 2'b00};
            if (redirect_valid) begin
                m_q.delete();
            end else begin
                if (pop) m_q.delete(0);
                if (hit && !m_rp) m_q.push_back({m_pc, m_pc ^ KEY});
            end
            if (e_fl)    m_fence = 1'b0;
            if (fence_i) m_fence = 1'b1;
            if (redirect_valid) begin
                if (miss_now) begin
                    m_rp  = 1'b1;
                    m_rpc = tgt;
                end else begin
                    m_pc = tgt;
                    m_rp = 1'b0;
                end
            end else if (hit) begin
                if (m_rp) begin
                    m_pc = m_rpc;
                    m_rp = 1'b0;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
            m_miss = miss_now;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            model_cycle();
            @(posedge clk);
            #1;
        end
    endtask

    int mark;
    int fc0;

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        fence_i = 1'b0;
        dec_ready = 1'b1;
        miss_addr = 32'hFFFF_FFF0;
        miss_end = 0;

        // Reset state
        step(3);
        chk1("rst_cache_valid", cache_valid, 1'b0);
        chk1("rst_cache_flush", cache_flush, 1'b0);
        chk1("rst_dec_valid", dec_valid, 1'b0);
        chk32("rst_cache_addr", cache_addr, 32'h0000_0100);
        rst = 1'b0;
        #1;
        chk1("first_cache_valid", cache_valid, 1'b1);
        chk1("first_dec_valid", dec_valid, 1'b0);

        // All hits, one per cycle
        step(1);
        chk1("latency_dec_valid", dec_valid, 1'b1);
        chk32("latency_dec_pc", dec_pc, 32'h0000_0100);
        step(3);
        chk32("hits_pc0", got_pc[0], 32'h0000_0100);
        chk32("hits_pc1", got_pc[1], 32'h0000_0104);
        chk32("hits_pc2", got_pc[2], 32'h0000_0108);
        chk32("hits_insn0", got_insn[0], 32'hA5A5_A4A5);
        chk32("hits_insn2", got_insn[2], 32'hA5A5_A4AD);
        chk32("hits_back_to_back1", 32'(got_cyc[1] - got_cyc[0]), 32'd1);
        chk32("hits_back_to_back2", 32'(got_cyc[2] - got_cyc[1]), 32'd1);

        // Backpressure: queue fills, fetch stops, resumes the cycle after a pop
        dec_ready = 1'b0;
        step(5);
        chk1("full_dec_valid", dec_valid, 1'b1);
        chk1("full_cache_valid", cache_valid, 1'b0);
        dec_ready = 1'b1;
        #1;
        chk1("full_still_stalled", cache_valid, 1'b0);
        step(1);
        chk1("full_resume", cache_valid, 1'b1);
        step(4);
        chk32("bp_xfer_count", 32'(got_pc.size()), 32'd8);
        for (int i = 0; i < got_pc.size(); i++)
            chk32("bp_order", got_pc[i], 32'h0000_0100 + 32'(4 * i));

        // Redirect during a 4-cycle miss at 0x200
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        miss_addr = 32'h0000_0200;
        miss_end = cyc + 4;
        step(1);
        redirect_valid = 1'b0;
        mark = got_pc.size();
        chk32("miss_addr_c1", cache_addr, 32'h0000_0200);
        chk1("miss_ready_c1", cache_ready, 1'b0);
        chk1("miss_dec_valid_c1", dec_valid, 1'b0);
        step(1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_1003;
        chk32("miss_addr_c2", cache_addr, 32'h0000_0200);
        step(1);
        redirect_valid = 1'b0;
        chk32("miss_addr_c3", cache_addr, 32'h0000_0200);
        step(1);
        chk32("miss_addr_c4", cache_addr, 32'h0000_0200);
        chk1("miss_ready_c4", cache_ready, 1'b1);
        step(1);
        chk32("redir_new_addr", cache_addr, 32'h0000_1000);
        chk1("redir_dec_valid", dec_valid, 1'b0);
        step(3);
        chk32("redir_first_pc", got_pc[mark], 32'h0000_1000);
        chk32("redir_second_pc", got_pc[mark + 1], 32'h0000_1004);

        // fence_i while a miss is outstanding
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0300;
        miss_addr = 32'h0000_0300;
        miss_end = cyc + 4;
        fc0 = flush_cnt;
        step(1);
        redirect_valid = 1'b0;
        fence_i = 1'b1;
        chk1("fence_m1_flush", cache_flush, 1'b0);
        chk1("fence_m1_valid", cache_valid, 1'b1);
        step(1);
        fence_i = 1'b0;
        chk1("fence_m2_flush", cache_flush, 1'b0);
        chk32("fence_m2_addr", cache_addr, 32'h0000_0300);
        step(2);
        chk1("fence_m4_flush", cache_flush, 1'b0);
        chk1("fence_m4_ready", cache_ready, 1'b1);
        step(1);
        chk1("fence_pulse_flush", cache_flush, 1'b1);
        chk1("fence_pulse_valid", cache_valid, 1'b0);
        chk32("fence_pulse_addr", cache_addr, 32'h0000_0304);
        step(1);
        chk1("fence_after_flush", cache_flush, 1'b0);
        chk1("fence_after_valid", cache_valid, 1'b1);
        chk32("fence_pulse_count", 32'(flush_cnt - fc0), 32'd1);

        // fence_i and redirect together: flush first, then the redirect target
        fence_i = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0400;
        step(1);
        fence_i = 1'b0;
        redirect_valid = 1'b0;
        chk1("fr_flush", cache_flush, 1'b1);
        chk1("fr_valid", cache_valid, 1'b0);
        chk32("fr_addr", cache_addr, 32'h0000_0400);
        step(1);
        chk1("fr_fetch_valid", cache_valid, 1'b1);
        chk32("fr_fetch_addr", cache_addr, 32'h0000_0400);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step(1);
        redirect_valid = 1'b0;
        mark = got_pc.size();
        step(4);
        chk32("wrap_pc0", got_pc[mark], 32'hFFFF_FFFC);
        chk32("wrap_pc1", got_pc[mark + 1], 32'h0000_0000);
        chk32("wrap_insn1", got_insn[mark + 1], 32'hA5A5_A5A5);

        // Redirect in the same cycle as a hit and a pop
        chk1("sim_pre_dec_valid", dec_valid, 1'b1);
        chk1("sim_pre_hit", cache_valid & cache_ready, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0500;
        step(1);
        redirect_valid = 1'b0;
        mark = got_pc.size();
        chk1("sim_dec_valid", dec_valid, 1'b0);
        chk32("sim_addr", cache_addr, 32'h0000_0500);
        step(3);
        chk32("sim_first_pc", got_pc[mark], 32'h0000_0500);

        // Reset in the middle of a miss
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0600;
        miss_addr = 32'h0000_0600;
        miss_end = cyc + 10;
        step(1);
        redirect_valid = 1'b0;
        fence_i = 1'b1;
        step(1);
        fence_i = 1'b0;
        rst = 1'b1;
        step(1);
        chk32("rstmiss_addr", cache_addr, 32'h0000_0100);
        chk1("rstmiss_dec_valid", dec_valid, 1'b0);
        chk1("rstmiss_cache_valid", cache_valid, 1'b0);
        rst = 1'b0;
        #1;
        chk1("rstmiss_resume_valid", cache_valid, 1'b1);
        chk1("rstmiss_no_flush", cache_flush, 1'b0);
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
